// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC and runs the single-outstanding req/gnt/rvalid
// handshake to imem, applying trap/redirect and holding the fetched instr under stall.
//
// Ports: clk, rst (async active-low); stallF from hazard unit; redirect_valid/redirect_pc
// from execute; trap_valid; imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata to memory;
// instr_valid_f/instr_f/pc_f/pc_plus4_f to the IF/ID register.
module fetch_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallF,
  input  logic                   redirect_valid,
  input  logic [DATA_WIDTH-1:0]  redirect_pc,
  input  logic                   trap_valid,
  output logic                   imem_req,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid_f,
  output logic [INSTR_WIDTH-1:0] instr_f,
  output logic [DATA_WIDTH-1:0]  pc_f,
  output logic [DATA_WIDTH-1:0]  pc_plus4_f
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   kill_q, kill_d;

  logic                   redir;
  logic [DATA_WIDTH-1:0]  target;

  // Trap wins over a simultaneous branch redirect.
  assign redir  = trap_valid | redirect_valid;
  assign target = trap_valid ? TRAP_VEC : redirect_pc;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    kill_d     = kill_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redir) begin
          fetch_pc_d = target;
        end
      end
      S_FETCH: begin
        // An ungranted request is not committed, so the
        // address may move to the new target.
        if (redir) begin
          fetch_pc_d = target;
        end
        if (imem_gnt) begin
          state_d = S_WAIT;
          kill_d  = redir;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_FETCH;
            if (redir) begin
              fetch_pc_d = target;
            end
          end else if (redir) begin
            fetch_pc_d = target;
            state_d    = S_FETCH;
          end else begin
            instr_d    = imem_rdata;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = S_HOLD;
          end
        end else if (redir) begin
          // Response still owed: mark it stale.
          fetch_pc_d = target;
          kill_d     = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir) begin
          valid_d    = 1'b0;
          fetch_pc_d = target;
          state_d    = S_FETCH;
        end else if (!stallF) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      kill_q     <= kill_d;
    end
  end

  assign imem_req      = (state_q == S_FETCH);
  assign imem_addr     = fetch_pc_q;
  assign instr_valid_f = valid_q;
  assign instr_f       = instr_q;
  assign pc_f          = pc_q;
  assign pc_plus4_f    = pc_q + PC_STEP;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a transaction-level model of the
// fetch sequencer and an imem responder; compares every cycle on the falling edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid_f;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .stallF        (stallF),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .trap_valid    (trap_valid),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid_f (instr_valid_f),
    .instr_f       (instr_f),
    .pc_f          (pc_f),
    .pc_plus4_f    (pc_plus4_f)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: flags describe where the single
  // fetch transaction stands, not the DUT's state register.
  bit          m_started;
  bit          m_inflight;
  bit          m_stale;
  bit          m_have;
  logic [31:0] m_pc;
  logic [31:0] m_pcf;
  logic [31:0] m_instr;
  wire         m_redir = trap_valid | redirect_valid;
  wire  [31:0] m_tgt = trap_valid ? 32'h100 : redirect_pc;

  initial begin
    m_pc = '0; m_pcf = '0; m_instr = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_started = 0; m_inflight = 0; m_stale = 0; m_have = 0;
        m_pc = 32'h0; m_pcf = '0; m_instr = '0;
      end else if (!m_started) begin
        m_started = 1;
        if (m_redir) m_pc = m_tgt;
      end else if (m_have) begin
        if (m_redir) begin
          m_have = 0; m_pc = m_tgt;
        end else if (!stallF) begin
          m_have = 0;
        end
      end else if (m_inflight) begin
        if (imem_rvalid) begin
          m_inflight = 0;
          if (m_stale) begin
            m_stale = 0;
            if (m_redir) m_pc = m_tgt;
          end else if (m_redir) begin
            m_pc = m_tgt;
          end else begin
            m_have = 1; m_instr = imem_rdata; m_pcf = m_pc;
            m_pc = m_pc + 32'd4;
          end
        end else if (m_redir) begin
          m_pc = m_tgt; m_stale = 1;
        end
      end else begin
        if (m_redir) m_pc = m_tgt;
        if (imem_gnt) begin
          m_inflight = 1; m_stale = m_redir;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("imem_req", imem_req, m_started && !m_inflight && !m_have);
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid_f", instr_valid_f, m_have);
      chk("instr_f", instr_f, m_instr);
      chk("pc_f", pc_f, m_pcf);
      chk("pc_plus4_f", pc_plus4_f, m_pcf + 32'd4);
    end
  end

  // imem responder and transaction logs.
  typedef struct {
    logic [31:0] addr;
    int          d;
  } resp_t;
  resp_t       pend[$];
  logic [31:0] grant_q[$];
  logic [31:0] deliv_q[$];
  int          rdelay = 0;
  bit          stale_seen = 0;

  task automatic tick();
    logic        g, c;
    logic [31:0] ga, cp;
    g  = rst && imem_req && imem_gnt;
    ga = imem_addr;
    c  = rst && instr_valid_f && !stallF;
    cp = pc_f;
    @(posedge clk);
    #1;
    if (g) grant_q.push_back(ga);
    if (c) deliv_q.push_back(cp);
    imem_rvalid = 1'b0;
    if (g) pend.push_back('{ga, rdelay});
    if (pend.size() > 0) begin
      if (pend[0].d == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        pend[0].d = pend[0].d - 1;
      end
    end
    if (!rst && imem_rvalid) stale_seen = 1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!instr_valid_f && n < 40) begin
      tick(); n++;
    end
    chk({nm, "_timeout"}, instr_valid_f, 1'b1);
  endtask

  task automatic wait_req(input string nm, input logic [31:0] a);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 40) begin
      tick(); n++;
    end
    chk({nm, "_timeout"}, imem_req && imem_addr == a, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int gsz;
    #1 rst = 1'b0;
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid_f, 0);
    tick(); tick();
    // T1: straight-line fetch 0,4,8
    imem_gnt = 1'b1;
    rst = 1'b1;
    n = 0;
    while (!(instr_valid_f && pc_f == 32'h8) && n < 30) begin
      tick(); n++;
    end
    chk("t1_cycles", n, 9);
    chk("t1_grants_n", grant_q.size(), 3);
    chk("t1_grant0", grant_q[0], 32'h0);
    chk("t1_grant1", grant_q[1], 32'h4);
    chk("t1_grant2", grant_q[2], 32'h8);
    chk("t1_deliv_n", deliv_q.size(), 2);
    chk("t1_deliv1", deliv_q[1], 32'h4);
    chk("t1_pc4", pc_plus4_f, 32'hC);
    chk("t1_instr", instr_f, mem(32'h8));
    chk("t1_model_pcf", m_pcf, 32'h8);
    chk("t1_model_pc", m_pc, 32'hC);
    // T2: stall in HOLD
    stallF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_valid", instr_valid_f, 1);
      chk("t2_pc", pc_f, 32'h8);
      chk("t2_noreq", imem_req, 0);
    end
    stallF = 1'b0;
    tick();
    chk("t2_deliv_n", deliv_q.size(), 3);
    chk("t2_next_req", imem_req, 1);
    chk("t2_next_addr", imem_addr, 32'hC);
    // T3: redirect together with gnt
    wait_req("t3_req", 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    wait_valid("t3_valid");
    chk("t3_pc", pc_f, 32'h40);
    chk("t3_instr", instr_f, mem(32'h40));
    chk("t3_g_old", grant_q[grant_q.size()-2], 32'h10);
    chk("t3_g_new", grant_q[grant_q.size()-1], 32'h40);
    chk("t3_deliv_last", deliv_q[deliv_q.size()-1], 32'hC);
    // T4: trap + redirect during WAIT
    rdelay = 2;
    wait_req("t4_req", 32'h44);
    tick();
    trap_valid = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    trap_valid = 1'b0;
    redirect_valid = 1'b0;
    rdelay = 0;
    wait_valid("t4_valid");
    chk("t4_pc", pc_f, 32'h100);
    chk("t4_instr", instr_f, mem(32'h100));
    chk("t4_g_old", grant_q[grant_q.size()-2], 32'h44);
    chk("t4_g_new", grant_q[grant_q.size()-1], 32'h100);
    // T5: redirect while gnt withheld
    imem_gnt = 1'b0;
    wait_req("t5_req", 32'h104);
    gsz = grant_q.size();
    tick();
    chk("t5_c1_addr", imem_addr, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_req", imem_req, 1);
      chk("t5_addr", imem_addr, 32'h200);
      tick();
    end
    chk("t5_nogrant", grant_q.size(), gsz);
    imem_gnt = 1'b1;
    rdelay = 3;
    tick();
    chk("t5_grant", grant_q[grant_q.size()-1], 32'h200);
    // T6: async reset mid-WAIT
    #2 rst = 1'b0;
    #1;
    chk("t6_req", imem_req, 0);
    chk("t6_valid", instr_valid_f, 0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_pc", pc_f, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_stale_seen", stale_seen, 1);
    gsz = grant_q.size();
    rdelay = 0;
    rst = 1'b1;
    wait_valid("t6_valid_after");
    chk("t6_first_grant", grant_q[gsz], 32'h0);
    chk("t6_pc_after", pc_f, 32'h0);
    chk("t6_instr_after", instr_f, mem(32'h0));
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the fetch stage: owns the fetch PC and runs the req/gnt/rvalid handshake to instruction memory, with one request outstanding at a time.
- Applies redirects from execute (taken branch/jump) and traps, and discards in-flight fetches made stale by a redirect.
- Holds the fetched instruction stable under hazard-unit stall.
- Sits between the hazard unit, the execute-stage branch logic, the instruction memory port and the IF/ID pipeline register.

Parameters:
- DATA_WIDTH, 32, width of all PC/address signals.
- INSTR_WIDTH, 32, width of instruction word.
- RESET_PC, 0, first fetch address after reset.
- TRAP_VEC, 32'h0000_0100, fetch address on trap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- stallF  in  1  hazard unit: 1 = decode cannot accept the instruction this cycle.
- redirect_valid  in  1  execute: taken branch/jump this cycle.
- redirect_pc  in  DATA_WIDTH  branch/jump target.
- trap_valid  in  1  trap request; goes to TRAP_VEC.
- imem_req  out  1  fetch request.
- imem_addr  out  DATA_WIDTH  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; earliest the cycle after gnt.
- imem_rdata  in  INSTR_WIDTH  read data.
- instr_valid_f  out  1  instr_f/pc_f hold a live instruction.
- instr_f  out  INSTR_WIDTH  fetched instruction.
- pc_f  out  DATA_WIDTH  address of instr_f.
- pc_plus4_f  out  DATA_WIDTH  pc_f + 4, combinational, modulo 2^DATA_WIDTH.

Behaviour:
- Registers:
  - fetch_pc: next address to request.
  - state: IDLE, FETCH, WAIT or HOLD.
  - kill flag.
  - instr_f, pc_f, instr_valid_f.
- Reset (rst=0, async):
  - state=IDLE, fetch_pc=RESET_PC, kill=0.
  - instr_valid_f=0, instr_f=0, pc_f=0; imem_req=0.
- imem_req=1 only in FETCH. imem_addr=fetch_pc, driven in all states.
- Event priority, checked every cycle in every state: trap_valid > redirect_valid > normal flow.
  - target = TRAP_VEC if trap_valid, else redirect_pc.
  - Redirects override stallF.
- IDLE:
  - Next cycle goes to FETCH.
  - A redirect or trap here loads fetch_pc=target.
- FETCH:
  - gnt=1, no redirect: go to WAIT.
  - gnt=0, no redirect: stay; imem_addr stays stable.
  - Redirect with gnt=0: fetch_pc=target, stay FETCH. The address changes the next cycle; imem permits this because a request without gnt is not committed.
  - Redirect with gnt=1: fetch_pc=target, kill=1, go to WAIT.
- WAIT:
  - rvalid=1, kill=0, no redirect: instr_f=rdata, pc_f=fetch_pc, instr_valid_f=1, fetch_pc+=4, go to HOLD.
  - rvalid=1, kill=1: drop the data, kill=0, go to FETCH. A redirect in this same cycle also loads fetch_pc=target.
  - Redirect, rvalid=0: fetch_pc=target, kill=1, stay WAIT.
  - Redirect, rvalid=1, kill=0: drop the data, fetch_pc=target, go to FETCH.
- HOLD (instr_valid_f=1):
  - Redirect: instr_valid_f=0, fetch_pc=target, go to FETCH.
  - Else stallF=1: hold all outputs unchanged.
  - Else (consumed this cycle): instr_valid_f=0, go to FETCH.
- Consumption rule: an instruction is consumed in exactly one cycle, the one where instr_valid_f=1 and stallF=0.
  - No instruction is ever delivered twice.
  - No unkilled response is ever lost except by a redirect.
- Throughput: best case one instruction per 3 cycles (FETCH, WAIT, HOLD).
- Address arithmetic: fetch_pc+4 wraps modulo 2^DATA_WIDTH. The low 2 bits of a redirect target are passed through unchanged.
- Reset asserted mid-transaction: return to reset values immediately. Any later rvalid for the abandoned request arrives in IDLE/FETCH and is ignored; rvalid is only sampled in WAIT.

Test Plan:
- Reset release, gnt=1 every cycle, rvalid one cycle after gnt, stallF=0 → imem_addr sequence 0,4,8. instr_valid_f pulses once per 3 cycles with pc_f=0,4,8. pc_plus4_f=4,8,12.
- stallF=1 for 4 cycles while in HOLD with pc_f=0x8 → instr_f/pc_f/instr_valid_f constant for 4 cycles, no imem_req. After stallF=0, next request is addr 0xC.
- redirect_valid with redirect_pc=0x40 in the same cycle as imem_gnt for addr 0x10 → the 0x10 response is dropped with no instr_valid_f. The next request is 0x40 and the next delivered pc_f=0x40.
- trap_valid and redirect_valid (0x80) asserted together during WAIT → response discarded. Next request is 0x100, delivered pc_f=0x100.
- imem_gnt held 0 for 5 cycles, redirect to 0x200 at cycle 2 → imem_req stays high. imem_addr switches to 0x200 the following cycle, and the granted address is 0x200.
- rst driven low mid-WAIT (async, between edges) → imem_req=0 and instr_valid_f=0 immediately, with no clock needed. A stale rvalid during reset is ignored. After release, first request is RESET_PC.
